// File: rtl/tbird_step_sequencer.sv
// Tail-light front end: synchronizes and debounces the driver switches,
// arbitrates them into a lighting mode, and paces the pattern step and dim clock.
module tbird_step_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int STEP_DIV   = 8,
  parameter int DIM_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       brk_raw,
  input  logic       hzd_raw,
  output logic       left,
  output logic       right,
  output logic       brk,
  output logic       hzd,
  output logic [1:0] mode,
  output logic       step,
  output logic       dimclk
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int STEP_W = $clog2(STEP_DIV + 1);
  localparam int DIM_W  = $clog2(DIM_DIV + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [DIM_W-1:0]  DIM_LAST  = DIM_W'(DIM_DIV - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_TURN   = 2'd1,
    MODE_BRAKE  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  // Bit order: 0 left, 1 right, 2 brake, 3 hazard.
  logic [3:0] raw_in;
  logic [3:0] deb_lvl;

  assign raw_in = {hzd_raw, brk_raw, right_raw, left_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      logic             sync1_q;
      logic             sync2_q;
      logic             lvl_q;
      logic             lvl_d;
      logic [DEB_W-1:0] cnt_q;
      logic [DEB_W-1:0] cnt_d;

      // The terminal count is reached on the cycle the counter would hit
      // DEB_CYCLES, so the level flips and the counter clears together.
      always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
          if (cnt_q == DEB_LAST) begin
            lvl_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          lvl_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw_in[gi];
          sync2_q <= sync1_q;
          lvl_q   <= lvl_d;
          cnt_q   <= cnt_d;
        end
      end

      assign deb_lvl[gi] = lvl_q;
    end
  endgenerate

  mode_t mode_d;
  mode_t mode_q;
  logic  mode_chg;

  always_comb begin
    mode_d = MODE_IDLE;
    if (deb_lvl[2]) begin
      mode_d = MODE_BRAKE;
    end else if (deb_lvl[3] | (deb_lvl[0] & deb_lvl[1])) begin
      mode_d = MODE_HAZARD;
    end else if (deb_lvl[0] ^ deb_lvl[1]) begin
      mode_d = MODE_TURN;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  logic [STEP_W-1:0] step_cnt_q;
  logic [STEP_W-1:0] step_cnt_d;
  logic              step_q;
  logic              step_d;

  // A mode change and a wrap on the same edge both land in the one pulse.
  always_comb begin
    step_cnt_d = step_cnt_q + 1'b1;
    step_d     = 1'b0;
    if (mode_chg || (step_cnt_q == STEP_LAST)) begin
      step_cnt_d = '0;
      step_d     = 1'b1;
    end
  end

  logic [DIM_W-1:0] dim_cnt_q;
  logic [DIM_W-1:0] dim_cnt_d;
  logic             dimclk_q;
  logic             dimclk_d;

  always_comb begin
    dim_cnt_d = dim_cnt_q + 1'b1;
    dimclk_d  = dimclk_q;
    if (dim_cnt_q == DIM_LAST) begin
      dim_cnt_d = '0;
      dimclk_d  = ~dimclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_IDLE;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      dim_cnt_q  <= '0;
      dimclk_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      dim_cnt_q  <= dim_cnt_d;
      dimclk_q   <= dimclk_d;
    end
  end

  assign left   = deb_lvl[0];
  assign right  = deb_lvl[1];
  assign brk    = deb_lvl[2];
  assign hzd    = deb_lvl[3];
  assign mode   = mode_q;
  assign step   = step_q;
  assign dimclk = dimclk_q;

endmodule

// File: tb/tb_tbird_step_sequencer.sv
// Directed bench for tbird_step_sequencer with default parameters; every
// expectation is written against the clock-edge count since reset release.
`timescale 1ns/1ps
module tb_tbird_step_sequencer;

  logic       clk;
  logic       rst;
  logic       left_raw;
  logic       right_raw;
  logic       brk_raw;
  logic       hzd_raw;
  logic       left;
  logic       right;
  logic       brk;
  logic       hzd;
  logic [1:0] mode;
  logic       step;
  logic       dimclk;

  int total;
  int bad;
  int cyc;

  tbird_step_sequencer #(
    .DEB_CYCLES(4),
    .STEP_DIV  (8),
    .DIM_DIV   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .left_raw (left_raw),
    .right_raw(right_raw),
    .brk_raw  (brk_raw),
    .hzd_raw  (hzd_raw),
    .left     (left),
    .right    (right),
    .brk      (brk),
    .hzd      (hzd),
    .mode     (mode),
    .step     (step),
    .dimclk   (dimclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input logic [1:0] e_mode, input logic e_step, input logic e_dim,
                           input logic e_l, input logic e_r, input logic e_b, input logic e_h);
    check("mode",   mode,            e_mode);
    check("step",   2'(step),        2'(e_step));
    check("dimclk", 2'(dimclk),      2'(e_dim));
    check("left",   2'(left),        2'(e_l));
    check("right",  2'(right),       2'(e_r));
    check("brk",    2'(brk),         2'(e_b));
    check("hzd",    2'(hzd),         2'(e_h));
    $display("edge %0d: mode=%0d step=%0b dim=%0b l=%0b r=%0b b=%0b h=%0b",
             cyc, mode, step, dimclk, left, right, brk, hzd);
  endtask

  initial begin
    logic [1:0] e_mode;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst       = 1'b0;
    left_raw  = 1'b0;
    right_raw = 1'b0;
    brk_raw   = 1'b0;
    hzd_raw   = 1'b0;

    #2 rst = 1'b1;
    #1 check_all(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Main run: idle cadence, turn entry, hazard timed onto a wrap,
    // brake glitch, accepted brake pulse, then back to turn.
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      cyc = k;
      if (k < 26)       e_mode = 2'd0;
      else if (k < 42)  e_mode = 2'd1;
      else if (k < 67)  e_mode = 2'd3;
      else if (k < 73)  e_mode = 2'd2;
      else if (k < 81)  e_mode = 2'd3;
      else              e_mode = 2'd1;
      check_all(e_mode,
                (k inside {8, 16, 24, 26, 34, 42, 50, 58, 66, 67, 73, 81, 89}),
                1'((k / 2) % 2),
                (k >= 25),
                (k >= 41) && (k < 80),
                (k >= 66) && (k <= 71),
                1'b0);
      if (k == 19) left_raw  = 1'b1;
      if (k == 35) right_raw = 1'b1;
      if (k == 50) brk_raw   = 1'b1;
      if (k == 53) brk_raw   = 1'b0;
      if (k == 60) brk_raw   = 1'b1;
      if (k == 66) brk_raw   = 1'b0;
      if (k == 74) right_raw = 1'b0;
    end

    // Asynchronous reset mid-operation with left_raw still high.
    rst = 1'b1;
    #1;
    cyc = 0;
    check_all(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cyc = k;
      if (k < 7)        e_mode = 2'd0;
      else if (k < 15)  e_mode = 2'd1;
      else              e_mode = 2'd3;
      check_all(e_mode,
                (k == 7) || (k == 15),
                1'((k / 2) % 2),
                (k >= 6),
                1'b0,
                1'b0,
                (k >= 14));
      if (k == 8) hzd_raw = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
